// File: rtl/uart_tx_fifo_drain_pkg.sv
// Shared constants for the UART transmit drain: FSM state codes, parity
// types and line levels.
package uart_tx_fifo_drain_pkg;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = S_IDLE,
      START  = S_START,
      DATA   = S_DATA,
      PARITY = S_PARITY,
      STOP   = S_STOP
   } tx_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // Stop bit and idle line share the high level.
   localparam logic IDLE_LVL  = 1'b1;
   localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// FIFO read port, parity configuration and serial line of the drain.
// master = FIFO/system side, slave = the drain itself.
interface uart_tx_fifo_drain_if
   import uart_tx_fifo_drain_pkg::*;
#(
   parameter int DATA_WIDTH = 8
);
   logic                  empty;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  par_en;
   logic                  par_typ;
   logic                  r_inc;
   logic                  tx_out;
   logic                  busy;

   modport master (
      output empty, rd_data, par_en, par_typ,
      input  r_inc, tx_out, busy
   );

   modport slave (
      input  empty, rd_data, par_en, par_typ,
      output r_inc, tx_out, busy
   );
endinterface

// File: rtl/uart_tx_fifo_drain_parity_calc.sv
// Combinational parity of a word; shared with the UART RX checker.
module parity_calc
   import uart_tx_fifo_drain_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  par_typ,
   output logic                  par
);

   // Even parity makes the total count of ones even, odd makes it odd.
   always_comb begin
      par = ^data;
      unique case (par_typ)
         PAR_EVEN: par = ^data;
         PAR_ODD:  par = ~^data;
         default:  par = ^data;
      endcase
   end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// Read-side consumer of the async FIFO in the UART TX bit-clock domain.
// Pops one word per frame and sends start, data LSB-first, optional
// parity and stop bit; back-to-back frames have no idle gap.
module uart_tx_fifo_drain
   import uart_tx_fifo_drain_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   uart_tx_fifo_drain_if.slave  bus
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   tx_state_e             state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [DATA_WIDTH-1:0] shift_q, shift_nxt;
   logic [DATA_WIDTH-1:0] data_q, data_nxt;
   logic                  par_en_q, par_en_nxt;
   logic                  par_typ_q, par_typ_nxt;
   logic                  tx_q, tx_nxt;
   logic                  busy_q, busy_nxt;
   logic                  pop;
   logic                  par_bit;

   // Parity is taken from the captured word, which stays stable while the
   // shift register drains.
   parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
      .data    (data_q),
      .par_typ (par_typ_q),
      .par     (par_bit)
   );

   // Next state plus the line bit and busy value of that next state, so the
   // output flops show the current state's values.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      shift_nxt   = shift_q;
      data_nxt    = data_q;
      par_en_nxt  = par_en_q;
      par_typ_nxt = par_typ_q;
      tx_nxt      = IDLE_LVL;
      busy_nxt    = 1'b0;
      pop         = 1'b0;
      unique case (state)
         IDLE: begin
            if (!bus.empty) pop = 1'b1;
         end
         START: begin
            state_nxt = DATA;
            cnt_nxt   = '0;
            tx_nxt    = shift_q[0];
            shift_nxt = shift_q >> 1;
            busy_nxt  = 1'b1;
         end
         DATA: begin
            busy_nxt = 1'b1;
            if (cnt == CNT_LAST) begin
               cnt_nxt = '0;
               if (par_en_q) begin
                  state_nxt = PARITY;
                  tx_nxt    = par_bit;
               end else begin
                  state_nxt = STOP;
                  tx_nxt    = IDLE_LVL;
               end
            end else begin
               cnt_nxt   = cnt + CNT_W'(1);
               tx_nxt    = shift_q[0];
               shift_nxt = shift_q >> 1;
            end
         end
         PARITY: begin
            state_nxt = STOP;
            tx_nxt    = IDLE_LVL;
            busy_nxt  = 1'b1;
         end
         STOP: begin
            if (!bus.empty) pop = 1'b1;
            else            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // A pop from IDLE or STOP starts the next frame straight away.
      if (pop) begin
         state_nxt   = START;
         data_nxt    = bus.rd_data;
         shift_nxt   = bus.rd_data;
         par_en_nxt  = bus.par_en;
         par_typ_nxt = bus.par_typ;
         tx_nxt      = START_LVL;
         busy_nxt    = 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Datapath, latched config and output flops; reset aborts any frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         tx_q      <= IDLE_LVL;
         busy_q    <= 1'b0;
      end else begin
         cnt       <= cnt_nxt;
         shift_q   <= shift_nxt;
         data_q    <= data_nxt;
         par_en_q  <= par_en_nxt;
         par_typ_q <= par_typ_nxt;
         tx_q      <= tx_nxt;
         busy_q    <= busy_nxt;
      end
   end

   assign bus.r_inc  = pop & ~rst;
   assign bus.tx_out = tx_q;
   assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Randomised and directed bench for uart_tx_fifo_drain. A FIFO queue feeds
// the DUT; a frame-level model predicts line bits, busy and pop strobes.
module tb_uart_tx_fifo_drain;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_tx_fifo_drain_if #(.DATA_WIDTH(8)) ifc ();

   uart_tx_fifo_drain #(.DATA_WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0] fifo_q[$];
   logic [1:0] exp_q[$];   // upcoming {busy, tx} per cycle
   logic       pend_pop = 1'b0;
   logic       pend_rst = 1'b0;
   logic       exp_tx, exp_busy, exp_rinc;
   logic       obs_tx, obs_busy, obs_rinc;

   // Whole frame for a word: start, 8 data LSB-first, parity?, stop.
   function automatic void push_frame(logic [7:0] w, logic pe, logic pt);
      int ones;
      exp_q.push_back(2'b10);
      for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, w[i]});
      ones = $countones(w);
      if (pe) exp_q.push_back({1'b1, (pt == 1'b0) ? logic'(ones % 2) : logic'(1 - ones % 2)});
      exp_q.push_back(2'b11);
   endfunction

   task automatic drive_fifo;
      ifc.empty   = (fifo_q.size() == 0);
      ifc.rd_data = (fifo_q.size() != 0) ? fifo_q[0] : 8'($urandom);
   endtask

   task automatic push(input logic [7:0] w);
      fifo_q.push_back(w);
      drive_fifo();
   endtask

   // One clock: sample mid-cycle, predict, then apply the edge's effects.
   task automatic tick;
      logic [1:0] cur;
      @(negedge clk);
      obs_tx   = ifc.tx_out;
      obs_busy = ifc.busy;
      obs_rinc = ifc.r_inc;
      cur = 2'b01;
      if (exp_q.size() != 0) begin
         cur = exp_q[0];
         exp_q.delete(0);
      end
      {exp_busy, exp_tx} = cur;
      // A new word may only be taken when the line is idle or on a stop bit.
      exp_rinc = (exp_q.size() == 0) && (fifo_q.size() != 0) && !rst;
      if (exp_rinc) begin
         push_frame(fifo_q[0], ifc.par_en, ifc.par_typ);
         pend_pop = 1'b1;
      end
      pend_rst = rst;
      @(posedge clk);
      #1;
      if (pend_pop) begin
         fifo_q.delete(0);
         pend_pop = 1'b0;
      end
      if (pend_rst) exp_q.delete();
      drive_fifo();
      cyc++;
   endtask

   task automatic test_reset;
      push(8'h5A);
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (obs_tx !== 1'b1 || obs_busy !== 1'b0 || obs_rinc !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold cyc=%0d tx=%b busy=%b r_inc=%b want 1/0/0", cyc, obs_tx, obs_busy, obs_rinc);
         end
      end
      rst = 1'b0;
      for (int i = 0; i < 14; i++) begin
         tick();
         total++;
         if (obs_tx !== exp_tx || obs_busy !== exp_busy || obs_rinc !== exp_rinc) begin
            bad++;
            $display("FAIL reset_release cyc=%0d tx=%b/%b busy=%b/%b r_inc=%b/%b (got/want)", cyc, obs_tx, exp_tx, obs_busy, exp_busy, obs_rinc, exp_rinc);
         end
      end
   endtask

   task automatic test_single;
      int n_rinc = 0, n_busy = 0;
      logic [9:0] seq = '0;
      ifc.par_en = 1'b0;
      push(8'hA5);
      for (int i = 0; i < 14; i++) begin
         tick();
         if (obs_rinc) n_rinc++;
         if (obs_busy) begin
            n_busy++;
            seq = {seq[8:0], obs_tx};
         end
         total++;
         if (obs_tx !== exp_tx || obs_busy !== exp_busy || obs_rinc !== exp_rinc) begin
            bad++;
            $display("FAIL single cyc=%0d tx=%b/%b busy=%b/%b r_inc=%b/%b (got/want)", cyc, obs_tx, exp_tx, obs_busy, exp_busy, obs_rinc, exp_rinc);
         end
      end
      total++;
      if (n_rinc != 1 || n_busy != 10 || seq !== 10'b0101001011) begin
         bad++;
         $display("FAIL single_frame pops=%0d busy=%0d bits=%b want 1/10/0101001011", n_rinc, n_busy, seq);
      end
   endtask

   task automatic test_parity;
      for (int t = 0; t < 2; t++) begin
         int n_busy = 0;
         logic pbit = 1'bx;
         logic want_p;
         want_p = (t == 0) ? 1'b1 : 1'b0;
         ifc.par_en  = 1'b1;
         ifc.par_typ = logic'(t);
         push(8'h07);
         for (int i = 0; i < 15; i++) begin
            tick();
            if (obs_busy) begin
               if (n_busy == 9) pbit = obs_tx;
               n_busy++;
            end
            total++;
            if (obs_tx !== exp_tx || obs_busy !== exp_busy || obs_rinc !== exp_rinc) begin
               bad++;
               $display("FAIL parity%0d cyc=%0d tx=%b/%b busy=%b/%b r_inc=%b/%b (got/want)", t, cyc, obs_tx, exp_tx, obs_busy, exp_busy, obs_rinc, exp_rinc);
            end
         end
         total++;
         if (n_busy != 11 || pbit !== want_p) begin
            bad++;
            $display("FAIL parity%0d_frame busy=%0d pbit=%b want 11/%b", t, n_busy, pbit, want_p);
         end
      end
      ifc.par_en = 1'b0;
   endtask

   task automatic test_back_to_back;
      int n_rinc = 0, n_busy = 0, first = -1, last = -1;
      ifc.par_en = 1'b0;
      push(8'h11);
      push(8'h22);
      push(8'h33);
      for (int i = 0; i < 36; i++) begin
         tick();
         if (obs_rinc) n_rinc++;
         if (obs_busy) begin
            n_busy++;
            if (first < 0) first = i;
            last = i;
         end
         total++;
         if (obs_tx !== exp_tx || obs_busy !== exp_busy || obs_rinc !== exp_rinc) begin
            bad++;
            $display("FAIL b2b cyc=%0d tx=%b/%b busy=%b/%b r_inc=%b/%b (got/want)", cyc, obs_tx, exp_tx, obs_busy, exp_busy, obs_rinc, exp_rinc);
         end
      end
      total++;
      if (n_rinc != 3 || n_busy != 30 || (last - first + 1) != 30) begin
         bad++;
         $display("FAIL b2b_summary pops=%0d busy=%0d span=%0d want 3/30/30", n_rinc, n_busy, last - first + 1);
      end
   endtask

   task automatic test_cfg_change;
      int n_busy = 0;
      ifc.par_en = 1'b0;
      push(8'h3C);
      push(8'h5A);
      for (int i = 0; i < 26; i++) begin
         tick();
         if (i == 3) ifc.par_en = 1'b1;   // word 0x3C is mid-DATA here
         if (obs_busy) n_busy++;
         total++;
         if (obs_tx !== exp_tx || obs_busy !== exp_busy || obs_rinc !== exp_rinc) begin
            bad++;
            $display("FAIL cfg_change cyc=%0d tx=%b/%b busy=%b/%b r_inc=%b/%b (got/want)", cyc, obs_tx, exp_tx, obs_busy, exp_busy, obs_rinc, exp_rinc);
         end
      end
      total++;
      if (n_busy != 21) begin
         bad++;
         $display("FAIL cfg_change_len busy=%0d want 21", n_busy);
      end
      ifc.par_en = 1'b0;
   endtask

   task automatic test_reset_mid;
      ifc.par_en = 1'b0;
      push(8'hC3);
      push(8'h96);
      // pop, START, DATA0..DATA2; RST is then high during DATA3
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b1;
      tick();
      tick();
      total++;
      if (obs_tx !== 1'b1 || obs_busy !== 1'b0 || obs_rinc !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid cyc=%0d tx=%b busy=%b r_inc=%b want 1/0/0", cyc, obs_tx, obs_busy, obs_rinc);
      end
      rst = 1'b0;
      tick();
      total++;
      if (obs_rinc !== 1'b1 || obs_busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_pop r_inc=%b busy=%b want 1/0", obs_rinc, obs_busy);
      end
      tick();
      total++;
      if (obs_tx !== 1'b0 || obs_busy !== 1'b1) begin
         bad++;
         $display("FAIL reset_mid_start tx=%b busy=%b want 0/1", obs_tx, obs_busy);
      end
      for (int i = 0; i < 11; i++) begin
         tick();
         total++;
         if (obs_tx !== exp_tx || obs_busy !== exp_busy || obs_rinc !== exp_rinc) begin
            bad++;
            $display("FAIL reset_mid_frame cyc=%0d tx=%b/%b busy=%b/%b r_inc=%b/%b (got/want)", cyc, obs_tx, exp_tx, obs_busy, exp_busy, obs_rinc, exp_rinc);
         end
      end
   endtask

   task automatic test_empty;
      int n_rinc = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (obs_rinc) n_rinc++;
         total++;
         if (obs_tx !== 1'b1 || obs_busy !== 1'b0) begin
            bad++;
            $display("FAIL empty cyc=%0d tx=%b busy=%b want 1/0", cyc, obs_tx, obs_busy);
         end
      end
      total++;
      if (n_rinc != 0) begin
         bad++;
         $display("FAIL empty_pops pops=%0d want 0", n_rinc);
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 600; i++) begin
         if (i < 550 && fifo_q.size() < 4 && $urandom_range(0, 9) < 3) push(8'($urandom));
         ifc.par_en  = 1'($urandom);
         ifc.par_typ = 1'($urandom);
         rst = (i < 550) && ($urandom_range(0, 99) == 0);
         tick();
         total++;
         if (obs_tx !== exp_tx || obs_busy !== exp_busy || obs_rinc !== exp_rinc) begin
            bad++;
            $display("FAIL random cyc=%0d tx=%b/%b busy=%b/%b r_inc=%b/%b (got/want)", cyc, obs_tx, exp_tx, obs_busy, exp_busy, obs_rinc, exp_rinc);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      ifc.par_en  = 1'b0;
      ifc.par_typ = 1'b0;
      drive_fifo();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_parity();
      test_back_to_back();
      test_cfg_change();
      test_reset_mid();
      test_empty();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
